phy_tx_scheduler: RTL and testbench

//  Owns the PHY transmit lane: one source per cycle feeds the transceiver TX port.

---
 rtl/phy_tx_scheduler_pkg.sv | 13 +
 rtl/phy_tx_scheduler.sv | 122 ++++++++++++
 tb/tb_phy_tx_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_scheduler_pkg.sv
// rtl/phy_tx_scheduler_pkg.sv - state encoding and lane primitive for the PHY TX scheduler
package phy_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_OOB       = 2'd0,
        ST_ALIGN     = 2'd1,
        ST_LINK_DATA = 2'd2
    } sched_state_t;

    // SATA ALIGN primitive (K28.5 D10.2 D10.2 D27.3), byte 0 is the K character
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;

endpackage

// File: rtl/phy_tx_scheduler.sv
// rtl/phy_tx_scheduler.sv - selects OOB, ALIGN bursts or link dwords onto the transceiver TX lane
module phy_tx_scheduler
    import phy_tx_scheduler_pkg::*;
#(
    parameter int ALIGN_INTERVAL = 254,
    parameter int ALIGN_BURST    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        linkup,
    input  logic [31:0] oob_tx_dout,
    input  logic        oob_tx_is_k,
    input  logic        oob_tx_set_elec_idle,
    input  logic [31:0] ll_tx_dout,
    input  logic        ll_tx_is_k,
    output logic        ll_tx_ready,
    output logic [31:0] phy_tx_dout,
    output logic        phy_tx_is_k,
    output logic        phy_tx_set_elec_idle,
    output logic        align_active,
    output logic [1:0]  sched_state
);

    localparam int CNT_W = $clog2(ALIGN_INTERVAL + 1);
    localparam int BST_W = $clog2(ALIGN_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALIGN_INTERVAL - 1);
    localparam logic [BST_W-1:0] BST_LAST = BST_W'(ALIGN_BURST - 1);

    sched_state_t     r_state;
    sched_state_t     w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [BST_W-1:0] r_burst_cnt;
    logic [BST_W-1:0] w_burst_next;

    logic [31:0]      w_dout;
    logic             w_is_k;
    logic             w_elec_idle;
    logic             w_align;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OOB;
            r_count     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_count_next;
            r_burst_cnt <= w_burst_next;
        end
    end

    // Dropping linkup wins over everything and clears both counters
    always_comb begin
        w_next_state = ST_OOB;
        w_count_next = '0;
        w_burst_next = '0;
        if (linkup) begin
            case (r_state)
                ST_OOB: w_next_state = ST_ALIGN;
                ST_ALIGN: begin
                    if (r_burst_cnt == BST_LAST) begin
                        w_next_state = ST_LINK_DATA;
                    end else begin
                        w_next_state = ST_ALIGN;
                        w_burst_next = r_burst_cnt + 1'b1;
                    end
                end
                ST_LINK_DATA: begin
                    if (r_count == CNT_LAST) begin
                        w_next_state = ST_ALIGN;
                    end else begin
                        w_next_state = ST_LINK_DATA;
                        w_count_next = r_count + 1'b1;
                    end
                end
                default: w_next_state = ST_OOB;
            endcase
        end
    end

    always_comb begin
        w_dout      = oob_tx_dout;
        w_is_k      = oob_tx_is_k;
        w_elec_idle = oob_tx_set_elec_idle;
        w_align     = 1'b0;
        if (linkup) begin
            case (r_state)
                ST_ALIGN: begin
                    w_dout      = PRIM_ALIGN;
                    w_is_k      = 1'b1;
                    w_elec_idle = 1'b0;
                    w_align     = 1'b1;
                end
                ST_LINK_DATA: begin
                    w_dout      = ll_tx_dout;
                    w_is_k      = ll_tx_is_k;
                    w_elec_idle = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_tx_dout          <= '0;
            phy_tx_is_k          <= 1'b0;
            phy_tx_set_elec_idle <= 1'b1;
            align_active         <= 1'b0;
        end else begin
            phy_tx_dout          <= w_dout;
            phy_tx_is_k          <= w_is_k;
            phy_tx_set_elec_idle <= w_elec_idle;
            align_active         <= w_align;
        end
    end

    assign ll_tx_ready = (r_state == ST_LINK_DATA) && linkup;
    assign sched_state = r_state;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// tb/tb_phy_tx_scheduler.sv - scoreboard bench for phy_tx_scheduler at default and 4/1 parameters
module tb_phy_tx_scheduler;

    localparam logic [31:0] ALIGN_PRIM = 32'h7B4A_4ABC;
    localparam logic [31:0] DIALTONE   = 32'h4A4A_4A4A;

    typedef struct {
        logic [31:0] dout;
        logic        is_k;
        logic        eidle;
        logic        align;
        logic [1:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        linkup;
    logic [31:0] oob_dout;
    logic        oob_k;
    logic        oob_ei;
    logic [31:0] ll_dout [2];
    logic        ll_k    [2];
    logic        ll_rdy  [2];
    logic [31:0] tx_dout [2];
    logic        tx_k    [2];
    logic        tx_ei   [2];
    logic        tx_al   [2];
    logic [1:0]  tx_st   [2];

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    bit   linked [2];
    int   pos    [2];
    int   widx   [2];
    int   src    [2];

    always #5 clk = ~clk;

    phy_tx_scheduler #(.ALIGN_INTERVAL(254), .ALIGN_BURST(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .linkup(linkup),
        .oob_tx_dout(oob_dout), .oob_tx_is_k(oob_k), .oob_tx_set_elec_idle(oob_ei),
        .ll_tx_dout(ll_dout[0]), .ll_tx_is_k(ll_k[0]), .ll_tx_ready(ll_rdy[0]),
        .phy_tx_dout(tx_dout[0]), .phy_tx_is_k(tx_k[0]), .phy_tx_set_elec_idle(tx_ei[0]),
        .align_active(tx_al[0]), .sched_state(tx_st[0])
    );

    phy_tx_scheduler #(.ALIGN_INTERVAL(4), .ALIGN_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .linkup(linkup),
        .oob_tx_dout(oob_dout), .oob_tx_is_k(oob_k), .oob_tx_set_elec_idle(oob_ei),
        .ll_tx_dout(ll_dout[1]), .ll_tx_is_k(ll_k[1]), .ll_tx_ready(ll_rdy[1]),
        .phy_tx_dout(tx_dout[1]), .phy_tx_is_k(tx_k[1]), .phy_tx_set_elec_idle(tx_ei[1]),
        .align_active(tx_al[1]), .sched_state(tx_st[1])
    );

    function automatic int interval_of(int i);
        return (i == 0) ? 254 : 4;
    endfunction

    function automatic int burst_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] word_val(int k);
        return 32'(k);
    endfunction

    function automatic logic word_k(int k);
        return (k % 5) == 3;
    endfunction

    task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, inst, $time, act, exp);
        end
    endtask

    task automatic check_out(input int i, input exp_t e);
        cmp("dout",  i, tx_dout[i], e.dout);
        cmp("is_k",  i, 32'(tx_k[i]), 32'(e.is_k));
        cmp("eidle", i, 32'(tx_ei[i]), 32'(e.eidle));
        cmp("align", i, 32'(tx_al[i]), 32'(e.align));
        cmp("state", i, 32'(tx_st[i]), 32'(e.st));
    endtask

    task automatic reset_checks();
        for (int i = 0; i < 2; i++) begin
            cmp("rst_dout",  i, tx_dout[i], 32'h0);
            cmp("rst_is_k",  i, 32'(tx_k[i]), 32'h0);
            cmp("rst_eidle", i, 32'(tx_ei[i]), 32'h1);
            cmp("rst_align", i, 32'(tx_al[i]), 32'h0);
            cmp("rst_ready", i, 32'(ll_rdy[i]), 32'h0);
            cmp("rst_state", i, 32'(tx_st[i]), 32'h0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb0.size() > 0) check_out(0, sb0.pop_front());
        if (sb1.size() > 0) check_out(1, sb1.pop_front());
    end

    // Link period after linkup: BURST aligns then INTERVAL words, repeating
    task automatic cycle(input bit dial);
        bit acc [2];
        oob_dout = dial ? DIALTONE : $urandom;
        oob_k    = dial ? 1'b0 : 1'($urandom);
        oob_ei   = dial ? 1'b0 : 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            ll_dout[i] = word_val(src[i]);
            ll_k[i]    = word_k(src[i]);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            bit   r;
            int   per;
            r   = 1'b0;
            per = burst_of(i) + interval_of(i);
            e.dout  = oob_dout;
            e.is_k  = oob_k;
            e.eidle = oob_ei;
            e.align = 1'b0;
            e.st    = 2'd0;
            if (!linkup) begin
                linked[i] = 1'b0;
            end else if (!linked[i]) begin
                linked[i] = 1'b1;
                pos[i]    = 0;
                e.st      = 2'd1;
            end else begin
                e.eidle = 1'b0;
                if ((pos[i] % per) < burst_of(i)) begin
                    e.dout  = ALIGN_PRIM;
                    e.is_k  = 1'b1;
                    e.align = 1'b1;
                end else begin
                    e.dout = word_val(widx[i]);
                    e.is_k = word_k(widx[i]);
                    r      = 1'b1;
                    widx[i]++;
                end
                pos[i]++;
                e.st = ((pos[i] % per) < burst_of(i)) ? 2'd1 : 2'd2;
            end
            cmp("ready", i, 32'(ll_rdy[i]), 32'(r));
            acc[i] = ll_rdy[i];
            if (i == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) if (acc[i]) src[i]++;
        @(negedge clk);
    endtask

    task automatic run(input bit lk, input int n, input bit dial);
        linkup = lk;
        repeat (n) cycle(dial);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        reset_checks();
        linkup = 1'b0;
        for (int i = 0; i < 2; i++) linked[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        linkup   = 1'b0;
        oob_dout = '0;
        oob_k    = 1'b0;
        oob_ei   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ll_dout[i] = '0;
            ll_k[i]    = 1'b0;
            linked[i]  = 1'b0;
            pos[i]     = 0;
            widx[i]    = 0;
            src[i]     = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 4, 1'b1);
        run(1'b1, 1 + 3 * (2 + 254) + 5, 1'b0);
        run(1'b0, 3, 1'b0);
        run(1'b1, 2, 1'b0);
        run(1'b0, 3, 1'b0);
        run(1'b1, 1 + 2 + 100, 1'b0);
        run(1'b0, 2, 1'b0);
        run(1'b1, 1 + 2 + 254 + 2 + 10, 1'b0);
        run(1'b1, 37, 1'b0);
        mid_reset();
        run(1'b0, 3, 1'b1);
        run(1'b1, 300, 1'b0);
        repeat (24) run(1'($urandom_range(0, 1)), $urandom_range(1, 40), 1'b0);
        run(1'b0, 2, 1'b0);
        @(posedge clk);
        #2;
        cmp("sb0_drained", 0, 32'(sb0.size()), 32'h0);
        cmp("sb1_drained", 1, 32'(sb1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
